uart_stream_bridge: RTL and testbench

//  Parametrised FIFO-buffered bridge between the UART core (byte + done / start + busy) and a host valid/ready stream.
//  RX bytes are buffered in an RX FIFO; host writes are buffered in a TX FIFO and sent by a start/busy handshake FSM.

---
 rtl/uart_fifo_pkg.sv | 16 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_stream_bridge.sv | 151 +++++++++++++++
 tb/tb_uart_stream_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the UART stream bridge and its FIFOs.
// Holds the TX handshake state encoding and the FIFO level-width function.
package uart_fifo_pkg;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_t;

    // One extra bit beyond the address so a full FIFO can report DEPTH.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head is visible with zero latency.
// Pointers carry one wrap bit so full and empty can be told apart without a counter.
module sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int LVL_W  = lvl_width(DEPTH),
    localparam int AW     = LVL_W - 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iPush,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iPop,
    output logic [DATA_W-1:0] oRdData,
    output logic              oFull,
    output logic              oEmpty,
    output logic [LVL_W-1:0]  oLevel
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0]  wr_ptr_q;
    logic [LVL_W-1:0]  wr_ptr_d;
    logic [LVL_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  rd_ptr_d;
    logic              push_ok;
    logic              pop_ok;

    assign oEmpty  = (wr_ptr_q == rd_ptr_q);
    assign oFull   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign oLevel  = wr_ptr_q - rd_ptr_q;

    // A push on a full FIFO is refused even when a pop happens in the same cycle.
    assign push_ok = iPush && !oFull;
    assign pop_ok  = iPop && !oEmpty;

    assign wr_ptr_d = push_ok ? wr_ptr_q + LVL_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop_ok  ? rd_ptr_q + LVL_W'(1) : rd_ptr_q;

    assign oRdData = oEmpty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= iWrData;
        end
    end

endmodule

// File: rtl/uart_stream_bridge.sv
// FIFO-buffered bridge between a UART core (byte/done, start/busy) and host valid/ready streams,
// with an internal RX->TX echo mode, level reporting and a sticky RX overflow flag.
module uart_stream_bridge
    import uart_fifo_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int LVL_W  = lvl_width(DEPTH)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iLoopback,
    input  logic [DATA_W-1:0] iRx_Data,
    input  logic              iRx_Done,
    output logic              oTx_Start,
    output logic [DATA_W-1:0] oTx_Data,
    input  logic              iTx_Busy,
    output logic [DATA_W-1:0] oRd_Data,
    output logic              oRd_Valid,
    input  logic              iRd_Ready,
    input  logic [DATA_W-1:0] iWr_Data,
    input  logic              iWr_Valid,
    output logic              oWr_Ready,
    output logic [LVL_W-1:0]  oRx_Level,
    output logic [LVL_W-1:0]  oTx_Level,
    output logic              oRx_Overflow,
    input  logic              iClr_Ovf
);

    logic              active_q;
    logic              loop_q;
    logic              ovf_q;
    logic              ovf_d;
    tx_state_t         state_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;

    logic [DATA_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic [DATA_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_wdata;
    logic              lb_xfer;
    logic              rd_valid;
    logic              wr_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .iClk    (iClk),
        .iRst    (iRst),
        .iPush   (iRx_Done),
        .iWrData (iRx_Data),
        .iPop    (rx_pop),
        .oRdData (rx_head),
        .oFull   (rx_full),
        .oEmpty  (rx_empty),
        .oLevel  (oRx_Level)
    );

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .iClk    (iClk),
        .iRst    (iRst),
        .iPush   (tx_push),
        .iWrData (tx_wdata),
        .iPop    (tx_pop),
        .oRdData (tx_head),
        .oFull   (tx_full),
        .oEmpty  (tx_empty),
        .oLevel  (oTx_Level)
    );

    // Host handshakes are held off until the first cycle after reset and while echoing.
    assign rd_valid = active_q && !loop_q && !rx_empty;
    assign wr_ready = active_q && !loop_q && !tx_full;
    assign lb_xfer  = active_q && loop_q && !rx_empty && !tx_full;

    assign rx_pop   = loop_q ? lb_xfer : (rd_valid && iRd_Ready);
    assign tx_push  = loop_q ? lb_xfer : (iWr_Valid && wr_ready);
    assign tx_wdata = loop_q ? rx_head : iWr_Data;

    assign oRd_Valid = rd_valid;
    assign oRd_Data  = rd_valid ? rx_head : '0;
    assign oWr_Ready = wr_ready;

    // A drop in the same cycle as a clear leaves the flag set.
    assign ovf_d = (iRx_Done && rx_full) ? 1'b1 :
                   (iClr_Ovf ? 1'b0 : ovf_q);

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            active_q <= 1'b1;
            ovf_q    <= ovf_d;
        end
    end

    // Mode is tracked through reset so the first cycle afterwards already reflects iLoopback.
    always_ff @(posedge iClk) begin
        loop_q <= iLoopback;
    end

    assign oRx_Overflow = ovf_q;

    assign tx_pop = (state_q == TX_IDLE) && !tx_empty && !iTx_Busy;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q    <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_data_q  <= tx_head;
                        tx_start_q <= 1'b1;
                        state_q    <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: begin
                    if (iTx_Busy) begin
                        state_q <= TX_WAIT_DONE;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!iTx_Busy) begin
                        state_q <= TX_IDLE;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign oTx_Start = tx_start_q;
    assign oTx_Data  = tx_data_q;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge: reset, host RX/TX, overflow, loopback echo and pointer wrap.
module tb_uart_stream_bridge;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = 5;

    logic              iClk = 1'b0;
    logic              iRst = 1'b0;
    logic              iLoopback = 1'b0;
    logic [DATA_W-1:0] iRx_Data = '0;
    logic              iRx_Done = 1'b0;
    logic              oTx_Start;
    logic [DATA_W-1:0] oTx_Data;
    logic              iTx_Busy = 1'b0;
    logic [DATA_W-1:0] oRd_Data;
    logic              oRd_Valid;
    logic              iRd_Ready = 1'b0;
    logic [DATA_W-1:0] iWr_Data = '0;
    logic              iWr_Valid = 1'b0;
    logic              oWr_Ready;
    logic [LVL_W-1:0]  oRx_Level;
    logic [LVL_W-1:0]  oTx_Level;
    logic              oRx_Overflow;
    logic              iClr_Ovf = 1'b0;

    uart_stream_bridge #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iLoopback    (iLoopback),
        .iRx_Data     (iRx_Data),
        .iRx_Done     (iRx_Done),
        .oTx_Start    (oTx_Start),
        .oTx_Data     (oTx_Data),
        .iTx_Busy     (iTx_Busy),
        .oRd_Data     (oRd_Data),
        .oRd_Valid    (oRd_Valid),
        .iRd_Ready    (iRd_Ready),
        .iWr_Data     (iWr_Data),
        .iWr_Valid    (iWr_Valid),
        .oWr_Ready    (oWr_Ready),
        .oRx_Level    (oRx_Level),
        .oTx_Level    (oTx_Level),
        .oRx_Overflow (oRx_Overflow),
        .iClr_Ovf     (iClr_Ovf)
    );

    always #5 iClk = ~iClk;

    int n_pass  = 0;
    int n_total = 0;

    // UART transmitter model: busy for 10 cycles after each start pulse.
    int          busy_cnt       = 0;
    int          start_cnt      = 0;
    int          stable_err     = 0;
    int          busy_start_err = 0;
    logic [7:0]  cur_data       = '0;
    logic [7:0]  start_log [$];

    always @(negedge iClk) begin
        if (iTx_Busy && oTx_Data !== cur_data) stable_err++;
        if (oTx_Start) begin
            if (iTx_Busy) busy_start_err++;
            start_cnt++;
            start_log.push_back(oTx_Data);
            cur_data = oTx_Data;
            busy_cnt = 10;
        end
        iTx_Busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 40 && iTx_Busy; i++) step();
        chk(tag, 32'(iTx_Busy), 32'd0);
        step();
        step();
    endtask

    initial begin
        logic [7:0] b;
        int         i;

        // 1: reset, traffic, reset mid-traffic, release
        iRst = 1'b0;
        step();
        step();
        iRst = 1'b1;
        step();
        chk("t1_ready_after_boot", 32'(oWr_Ready), 32'd1);
        iRx_Done = 1'b1; iRx_Data = 8'h5A;
        iWr_Valid = 1'b1; iWr_Data = 8'h77;
        step();
        iRx_Done = 1'b0; iWr_Valid = 1'b0;
        chk("t1_rx_level_pre", 32'(oRx_Level), 32'd1);
        step();
        iRst = 1'b0;
        iRx_Done = 1'b1; iRx_Data = 8'h99;
        iWr_Valid = 1'b1; iWr_Data = 8'h66;
        step();
        step();
        step();
        chk("t1_rst_rx_level", 32'(oRx_Level), 32'd0);
        chk("t1_rst_tx_level", 32'(oTx_Level), 32'd0);
        chk("t1_rst_rd_valid", 32'(oRd_Valid), 32'd0);
        chk("t1_rst_rd_data", 32'(oRd_Data), 32'd0);
        chk("t1_rst_wr_ready", 32'(oWr_Ready), 32'd0);
        chk("t1_rst_tx_start", 32'(oTx_Start), 32'd0);
        chk("t1_rst_tx_data", 32'(oTx_Data), 32'd0);
        chk("t1_rst_ovf", 32'(oRx_Overflow), 32'd0);
        iRx_Done = 1'b0; iWr_Valid = 1'b0;
        iRst = 1'b1;
        step();
        chk("t1_rel_wr_ready", 32'(oWr_Ready), 32'd1);
        chk("t1_rel_rx_level", 32'(oRx_Level), 32'd0);
        chk("t1_rel_rd_valid", 32'(oRd_Valid), 32'd0);
        wait_idle("t1_busy_timeout");

        // 2: host RX ordering and one-cycle latency
        iRx_Done = 1'b1; iRx_Data = 8'hA5;
        step();
        chk("t2_valid_latency", 32'(oRd_Valid), 32'd1);
        iRx_Data = 8'h3C;
        step();
        iRx_Data = 8'hFF;
        step();
        iRx_Done = 1'b0;
        chk("t2_rx_level", 32'(oRx_Level), 32'd3);
        chk("t2_head", 32'(oRd_Data), 32'hA5);
        iRd_Ready = 1'b1;
        chk("t2_rd0", 32'(oRd_Data), 32'hA5);
        step();
        chk("t2_rd1", 32'(oRd_Data), 32'h3C);
        step();
        chk("t2_rd2", 32'(oRd_Data), 32'hFF);
        step();
        iRd_Ready = 1'b0;
        chk("t2_empty_valid", 32'(oRd_Valid), 32'd0);
        chk("t2_empty_level", 32'(oRx_Level), 32'd0);

        // 3: overflow; the 17th byte arrives together with a clear, and the set must win
        for (i = 0; i < 16; i++) begin
            iRx_Done = 1'b1; iRx_Data = 8'(i + 1);
            step();
        end
        chk("t3_full_no_ovf", 32'(oRx_Overflow), 32'd0);
        iRx_Data = 8'd17; iClr_Ovf = 1'b1;
        step();
        iRx_Done = 1'b0; iClr_Ovf = 1'b0;
        chk("t3_level16", 32'(oRx_Level), 32'd16);
        chk("t3_ovf_set", 32'(oRx_Overflow), 32'd1);
        iRd_Ready = 1'b1;
        for (i = 0; i < 16; i++) begin
            chk($sformatf("t3_drain%0d", i), 32'(oRd_Data), 32'(i + 1));
            step();
        end
        iRd_Ready = 1'b0;
        chk("t3_17th_absent", 32'(oRd_Valid), 32'd0);
        chk("t3_ovf_sticky", 32'(oRx_Overflow), 32'd1);
        iClr_Ovf = 1'b1;
        step();
        iClr_Ovf = 1'b0;
        chk("t3_ovf_clr", 32'(oRx_Overflow), 32'd0);

        // 4: host TX with busy handshake
        start_cnt = 0; stable_err = 0; busy_start_err = 0;
        start_log.delete();
        iWr_Valid = 1'b1; iWr_Data = 8'h11;
        chk("t4_ready0", 32'(oWr_Ready), 32'd1);
        step();
        chk("t4_tx_level1", 32'(oTx_Level), 32'd1);
        iWr_Data = 8'h22;
        chk("t4_ready1", 32'(oWr_Ready), 32'd1);
        step();
        iWr_Valid = 1'b0;
        chk("t4_tx_level_pushpop", 32'(oTx_Level), 32'd1);
        for (i = 0; i < 80 && !(start_cnt >= 2 && !iTx_Busy); i++) step();
        chk("t4_done_timeout", 32'((start_cnt >= 2) && !iTx_Busy), 32'd1);
        step();
        step();
        step();
        chk("t4_start_count", 32'(start_cnt), 32'd2);
        chk("t4_data0", 32'(start_log.size() > 0 ? start_log[0] : 8'h00), 32'h11);
        chk("t4_data1", 32'(start_log.size() > 1 ? start_log[1] : 8'h00), 32'h22);
        chk("t4_stable", 32'(stable_err), 32'd0);
        chk("t4_no_start_busy", 32'(busy_start_err), 32'd0);
        chk("t4_tx_empty", 32'(oTx_Level), 32'd0);

        // 5: loopback echo, three-cycle latency
        iLoopback = 1'b1;
        step();
        chk("t5_wr_ready", 32'(oWr_Ready), 32'd0);
        iRx_Done = 1'b1; iRx_Data = 8'h55;
        step();
        iRx_Done = 1'b0;
        chk("t5_c1_start", 32'(oTx_Start), 32'd0);
        chk("t5_c1_rd_valid", 32'(oRd_Valid), 32'd0);
        chk("t5_c1_rx_level", 32'(oRx_Level), 32'd1);
        step();
        chk("t5_c2_start", 32'(oTx_Start), 32'd0);
        chk("t5_c2_rd_valid", 32'(oRd_Valid), 32'd0);
        chk("t5_c2_tx_level", 32'(oTx_Level), 32'd1);
        chk("t5_c2_rx_level", 32'(oRx_Level), 32'd0);
        step();
        chk("t5_c3_start", 32'(oTx_Start), 32'd1);
        chk("t5_c3_data", 32'(oTx_Data), 32'h55);
        chk("t5_c3_wr_ready", 32'(oWr_Ready), 32'd0);
        step();
        chk("t5_c4_start", 32'(oTx_Start), 32'd0);
        wait_idle("t5_busy_timeout");
        chk("t5_start_count", 32'(start_cnt), 32'd3);
        iLoopback = 1'b0;
        step();

        // 6: streaming push+pop across pointer wrap, level stays 1
        iRx_Done = 1'b1; iRx_Data = 8'h80;
        step();
        for (i = 0; i < 40; i++) begin
            b = 8'(8'h80 + i);
            iRx_Done = 1'b1; iRx_Data = 8'(b + 8'd1); iRd_Ready = 1'b1;
            chk($sformatf("t6_data%0d", i), 32'(oRd_Data), 32'(b));
            chk($sformatf("t6_level%0d", i), 32'(oRx_Level), 32'd1);
            step();
        end
        iRx_Done = 1'b0;
        chk("t6_last", 32'(oRd_Data), 32'hA8);
        step();
        iRd_Ready = 1'b0;
        chk("t6_drained", 32'(oRd_Valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
